// File: rtl/rvc_asap_5pl_vga_ctrl.sv
// VGA 640x480@60Hz controller: scans a 1-bpp frame buffer, serialises 32-bit words
// into pixels and drives syncs and 12-bit RGB through a fixed 2-cycle pipeline.
module rvc_asap_5pl_vga_ctrl #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic [11:0] FG_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic        Clock,
    input  logic        Rst,
    output logic [13:0] address_b,
    input  logic [31:0] q_b,
    output logic [3:0]  RED,
    output logic [3:0]  GREEN,
    output logic [3:0]  BLUE,
    output logic        h_sync,
    output logic        v_sync,
    output logic        frame_start
);

    localparam logic [9:0]  H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0]  H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0]  V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0]  VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [13:0] LINE_WORDS = 14'(H_VISIBLE / 32);

    // Scan counters and the running word address of the current line's first word
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [13:0] line_base_q, line_base_d;

    // Stage 1: fetch bookkeeping plus delayed visible/sync terms
    logic [13:0] addr_hold_q, addr_hold_d;
    logic        load_q, load_d;
    logic        vis1_q, vis1_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic        fs1_q, fs1_d;

    // Stage 2: pixel serialiser and registered pins
    logic [31:0] shift_q, shift_d;
    logic [11:0] rgb_q, rgb_d;
    logic        h_sync_q, h_sync_d;
    logic        v_sync_q, v_sync_d;
    logic        frame_start_q, frame_start_d;

    logic        h_end;
    logic        v_end;
    logic        visible;
    logic        fetch;
    logic [13:0] fetch_addr;
    logic        pix_bit;

    always_comb begin
        h_end       = (h_cnt_q == H_LAST);
        v_end       = (v_cnt_q == V_LAST);
        h_cnt_d     = h_end ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d     = v_cnt_q;
        line_base_d = line_base_q;
        if (h_end) begin
            if (v_end) begin
                v_cnt_d     = 10'd0;
                line_base_d = 14'd0;
            end else begin
                v_cnt_d     = v_cnt_q + 10'd1;
                line_base_d = line_base_q + LINE_WORDS;
            end
        end
    end

    // The address is presented combinationally in the fetch cycle so the
    // memory's registered read returns the word on the very next cycle.
    always_comb begin
        visible     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        fetch       = visible && (h_cnt_q[4:0] == 5'd0);
        fetch_addr  = line_base_q + 14'(h_cnt_q[9:5]);
        address_b   = fetch ? fetch_addr : addr_hold_q;
        addr_hold_d = address_b;
        load_d      = fetch;
        vis1_d      = visible;
        hs1_d       = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs1_d       = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        fs1_d       = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end

    // On the load cycle the pixel comes straight from q_b; the register keeps
    // the remaining 31 bits already shifted into place.
    always_comb begin
        pix_bit       = load_q ? q_b[0] : shift_q[0];
        shift_d       = load_q ? {1'b0, q_b[31:1]} : {1'b0, shift_q[31:1]};
        rgb_d         = vis1_q ? (pix_bit ? FG_COLOR : BG_COLOR) : 12'h000;
        h_sync_d      = hs1_q;
        v_sync_d      = vs1_q;
        frame_start_d = fs1_q;
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            line_base_q   <= 14'd0;
            addr_hold_q   <= 14'd0;
            load_q        <= 1'b0;
            vis1_q        <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            fs1_q         <= 1'b0;
            shift_q       <= 32'd0;
            rgb_q         <= 12'h000;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_base_q   <= line_base_d;
            addr_hold_q   <= addr_hold_d;
            load_q        <= load_d;
            vis1_q        <= vis1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            fs1_q         <= fs1_d;
            shift_q       <= shift_d;
            rgb_q         <= rgb_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign {RED, GREEN, BLUE} = rgb_q;
    assign h_sync             = h_sync_q;
    assign v_sync             = v_sync_q;
    assign frame_start        = frame_start_q;

endmodule

// File: tb/tb_rvc_asap_5pl_vga_ctrl.sv
// Bench for the VGA controller using a reduced display geometry so whole frames
// fit in a short run; a pixel-level model predicts every output pin each cycle.
module tb_rvc_asap_5pl_vga_ctrl;

    localparam int HV = 96, HF = 8, HS = 16, HB = 8;
    localparam int VV = 8, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 128
    localparam int VT = VV + VF + VS + VB;   // 15
    localparam int FT = HT * VT;             // 1920
    localparam int WPL = HV / 32;            // 3
    localparam int MEM_WORDS = 9600;
    localparam logic [14:0] RST_PINS = {12'h000, 1'b1, 1'b1, 1'b0};

    logic        Clock = 1'b0;
    logic        Rst = 1'b1;
    logic [13:0] address_b;
    logic [31:0] q_b;
    logic [3:0]  RED, GREEN, BLUE;
    logic        h_sync, v_sync, frame_start;

    logic [31:0] mem [MEM_WORDS];

    int n_checks = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    // Model state: scan position, last fetched address, expected-pins queue
    int m_h = 0, m_v = 0, m_last = 0;
    logic [14:0] exp_q[$];
    logic [14:0] cur_exp = RST_PINS;

    rvc_asap_5pl_vga_ctrl #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .Clock(Clock), .Rst(Rst), .address_b(address_b), .q_b(q_b),
        .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
        .h_sync(h_sync), .v_sync(v_sync), .frame_start(frame_start)
    );

    // Clock / reset block
    always #20 Clock = ~Clock;

    // Frame-buffer memory with a 1-cycle registered read
    always @(posedge Clock) begin
        if (address_b < 14'(MEM_WORDS)) q_b <= mem[address_b];
        else q_b <= 32'hDEAD_BEEF;
    end

    function automatic logic [14:0] pins_for(input int h, input int v);
        logic        vis, b, hs, vs, fs;
        logic [31:0] w;
        logic [11:0] rgb;
        vis = (h < HV) && (v < VV);
        b   = 1'b0;
        if (vis) begin
            w = mem[v * WPL + h / 32];
            b = w[h % 32];
        end
        rgb = (vis && b) ? 12'hFFF : 12'h000;
        hs  = !(h >= HV + HF && h < HV + HF + HS);
        vs  = !(v >= VV + VF && v < VV + VF + VS);
        fs  = (h == 0) && (v == 0);
        return {rgb, hs, vs, fs};
    endfunction

    function automatic bit is_fetch(input int h, input int v);
        return (h < HV) && (v < VV) && (h % 32 == 0);
    endfunction

    function automatic int exp_addr();
        return is_fetch(m_h, m_v) ? (m_v * WPL + m_h / 32) : m_last;
    endfunction

    // Reference model: pins appear two clock edges after the scan position
    always @(posedge Clock) begin
        if (Rst) begin
            m_h = 0; m_v = 0; m_last = 0;
            exp_q.delete();
            exp_q.push_back(RST_PINS);
            cur_exp = RST_PINS;
        end else begin
            if (is_fetch(m_h, m_v)) m_last = m_v * WPL + m_h / 32;
            exp_q.push_back(pins_for(m_h, m_v));
            cur_exp = exp_q.pop_front();
            m_h = m_h + 1;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare every cycle
    always @(negedge Clock) begin
        if (chk_en) begin
            check("rgb", 32'({RED, GREEN, BLUE}), 32'(cur_exp[14:3]));
            check("h_sync", 32'(h_sync), 32'(cur_exp[2]));
            check("v_sync", 32'(v_sync), 32'(cur_exp[1]));
            check("frame_start", 32'(frame_start), 32'(cur_exp[0]));
            check("address_b", 32'(address_b), 32'(exp_addr()));
        end
    end

    // Driver: hold reset for one edge while loading memory (mode 0 zero, 1 ones, 2 random)
    task automatic reset_fill(input int mode);
        @(negedge Clock);
        Rst = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++)
            mem[i] = (mode == 0) ? 32'h0 : (mode == 1) ? 32'hFFFF_FFFF : $urandom;
        @(negedge Clock);
        Rst = 1'b0;
    endtask

    task automatic mid_reset_check();
        logic [31:0] w0;
        w0 = mem[0];
        Rst = 1'b1;
        @(negedge Clock);
        Rst = 1'b0;
        check("mid_rst_rgb", 32'({RED, GREEN, BLUE}), 32'h0);
        check("mid_rst_hs", 32'(h_sync), 32'h1);
        check("mid_rst_vs", 32'(v_sync), 32'h1);
        check("mid_rst_fs", 32'(frame_start), 32'h0);
        check("mid_rst_addr", 32'(address_b), 32'h0);
        repeat (2) @(negedge Clock);
        check("post_rst_fs", 32'(frame_start), 32'h1);
        check("post_rst_px0", 32'({RED, GREEN, BLUE}), w0[0] ? 32'hFFF : 32'h0);
    endtask

    initial begin
        int first_hs, hs_low, vs_low, n_fs, cnt_fff;
        int fs_at[4];
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
        repeat (3) @(negedge Clock);

        // Pixel order, address sweep and sync timing
        chk_en = 1'b1;
        reset_fill(0);
        mem[0] = 32'h0000_0005;
        first_hs = -1; hs_low = 0; vs_low = 0; n_fs = 0;
        for (int k = 1; k <= 2 * FT + 4; k++) begin
            @(negedge Clock);
            if (k == 1) check("px_pre_fs", 32'(frame_start), 32'h0);
            if (k == 2) begin
                check("px0_fs", 32'(frame_start), 32'h1);
                check("px0", 32'({RED, GREEN, BLUE}), 32'hFFF);
            end
            if (k == 3) check("px1", 32'({RED, GREEN, BLUE}), 32'h000);
            if (k == 4) check("px2", 32'({RED, GREEN, BLUE}), 32'hFFF);
            if (k == 5) check("px3", 32'({RED, GREEN, BLUE}), 32'h000);
            if (k == 32) check("addr_32_0", 32'(address_b), 32'd1);
            if (k == 100) check("addr_hold_hblank", 32'(address_b), 32'd2);
            if (k == HT) check("addr_0_1", 32'(address_b), 32'd3);
            if (k == 7 * HT + 64) check("addr_last", 32'(address_b), 32'd23);
            if (k == 7 * HT + 65) check("addr_last_hold", 32'(address_b), 32'd23);
            if (k == 9 * HT) check("addr_hold_vblank", 32'(address_b), 32'd23);
            if (k <= HT && h_sync == 1'b0) begin
                hs_low++;
                if (first_hs < 0) first_hs = k;
            end
            if (k <= FT && v_sync == 1'b0) vs_low++;
            if (frame_start && n_fs < 4) begin
                fs_at[n_fs] = k;
                n_fs++;
            end
        end
        check("hs_first_low", 32'(first_hs), 32'(HV + HF + 2));
        check("hs_low_len", 32'(hs_low), 32'(HS));
        check("vs_low_len", 32'(vs_low), 32'(VS * HT));
        check("fs_count", 32'(n_fs), 32'd3);
        if (n_fs >= 2) check("frame_period", 32'(fs_at[1] - fs_at[0]), 32'(FT));

        // All-ones memory: every visible pixel lit, blanking dark
        reset_fill(1);
        cnt_fff = 0;
        for (int k = 1; k <= FT + 4; k++) begin
            @(negedge Clock);
            if (k <= FT && {RED, GREEN, BLUE} == 12'hFFF) cnt_fff++;
        end
        check("lit_pixels", 32'(cnt_fff), 32'(HV * VV));

        // Word boundary between words 0 and 1
        reset_fill(0);
        mem[0] = 32'h8000_0000;
        mem[1] = 32'h0000_0001;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clock);
            if (k == 32) check("px30", 32'({RED, GREEN, BLUE}), 32'h000);
            if (k == 33) check("px31", 32'({RED, GREEN, BLUE}), 32'hFFF);
            if (k == 34) check("px32", 32'({RED, GREEN, BLUE}), 32'hFFF);
            if (k == 35) check("px33", 32'({RED, GREEN, BLUE}), 32'h000);
        end

        // Random images with mid-frame resets
        for (int it = 0; it < 4; it++) begin
            int stop_k;
            reset_fill(2);
            stop_k = (it == 0) ? (5 * HT + 40) : int'($urandom_range(1, FT + 300));
            repeat (stop_k) @(negedge Clock);
            mid_reset_check();
            repeat (FT / 2 + int'($urandom_range(0, 200))) @(negedge Clock);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
